divider_8bit: RTL and testbench

DIVIDER_8BIT -- requirements
Module: divider_8bit

---
 rtl/divider_8bit_pkg.sv | 21 ++
 rtl/subtractor_9bit.sv | 28 ++
 rtl/divider_8bit.sv | 128 ++++++++++++
 tb/tb_divider_8bit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_8bit_pkg.sv
// Shared definitions for the 8-bit restoring divider: data width, step count
// and the three-state FSM encoding.
package divider_8bit_pkg;

  localparam int DATA_W = 8;
  localparam int STEPS  = 8;
  localparam int PREM_W = DATA_W + 1;
  localparam int CNT_W  = 3;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Terminal step flag: the counter value at which the last restoring step runs.
  function automatic logic is_last_step(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_W'(STEPS - 1));
  endfunction

endpackage

// File: rtl/subtractor_9bit.sv
// Trial subtraction for the restoring divider: diff = a - b built as a + ~b + 1
// through a ripple of full adders; borrow=0 means a >= b.
module subtractor_9bit
  import divider_8bit_pkg::*;
(
  input  logic [PREM_W-1:0] a,
  input  logic [PREM_W-1:0] b,
  output logic [PREM_W-1:0] diff,
  output logic              borrow
);

  logic [PREM_W:0]   carry_s;
  logic [PREM_W-1:0] b_inv_s;

  // Ripple full-add chain with the +1 injected as carry-in of bit 0.
  always_comb begin
    carry_s    = '0;
    diff       = '0;
    b_inv_s    = ~b;
    carry_s[0] = 1'b1;
    for (int i = 0; i < PREM_W; i++) begin
      diff[i]      = a[i] ^ b_inv_s[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b_inv_s[i]) | (carry_s[i] & (a[i] ^ b_inv_s[i]));
    end
    borrow = ~carry_s[PREM_W];
  end

endmodule

// File: rtl/divider_8bit.sv
// 8-bit unsigned restoring divider: one quotient bit per clock, MSB first,
// with a dedicated one-cycle path for divide-by-zero.
module divider_8bit
  import divider_8bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);

  state_t            state_r;
  logic [DATA_W-1:0] dvd_r;
  logic [DATA_W-1:0] dvs_r;
  logic [PREM_W-1:0] p_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] quotient_r;
  logic [DATA_W-1:0] remainder_r;
  logic              busy_r;
  logic              done_r;
  logic              div_zero_r;

  logic [PREM_W-1:0] p_shift_s;
  logic [PREM_W-1:0] diff_s;
  logic              borrow_s;
  logic [PREM_W-1:0] p_upd_s;
  logic              q_bit_s;
  logic              term_s;
  logic [DATA_W-1:0] q_next_s;
  logic              unused_p_msb_s;

  // dvd_r doubles as the quotient shift register: dividend bits leave at the
  // top while quotient bits enter at the bottom.
  always_comb begin
    p_shift_s = {p_r[DATA_W-1:0], dvd_r[DATA_W-1]};
  end

  subtractor_9bit u_sub (
    .a      (p_shift_s),
    .b      ({1'b0, dvs_r}),
    .diff   (diff_s),
    .borrow (borrow_s)
  );

  // Restore on borrow, otherwise keep the difference and emit a 1 bit.
  always_comb begin
    q_bit_s        = ~borrow_s;
    term_s         = is_last_step(cnt_r);
    q_next_s       = {dvd_r[DATA_W-2:0], q_bit_s};
    unused_p_msb_s = p_r[PREM_W-1];
    if (borrow_s) begin
      p_upd_s = p_shift_s;
    end else begin
      p_upd_s = diff_s;
    end
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      dvd_r       <= '0;
      dvs_r       <= '0;
      p_r         <= '0;
      cnt_r       <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_zero_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            dvd_r      <= dividend;
            dvs_r      <= divisor;
            p_r        <= '0;
            cnt_r      <= '0;
            div_zero_r <= 1'b0;
            if (divisor == 8'd0) begin
              state_r     <= ST_DONE;
              quotient_r  <= 8'hFF;
              remainder_r <= dividend;
              div_zero_r  <= 1'b1;
              done_r      <= 1'b1;
            end else begin
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          p_r   <= p_upd_s;
          dvd_r <= q_next_s;
          cnt_r <= cnt_r + 3'd1;
          if (term_s) begin
            state_r     <= ST_DONE;
            busy_r      <= 1'b0;
            done_r      <= 1'b1;
            quotient_r  <= q_next_s;
            remainder_r <= p_upd_s[DATA_W-1:0];
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign div_zero  = div_zero_r;

endmodule

// File: tb/tb_divider_8bit.sv
// Self-checking bench for divider_8bit: directed vector table, hand-written
// corner sequences, and a randomized run against a plain-arithmetic model.
module tb_divider_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_zero;

  int checks   = 0;
  int failures = 0;
  int cur_a    = 0;
  int cur_b    = 0;

  always #5 clk = ~clk;

  divider_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s (op %0d/%0d): got %0d expected %0d", name, cur_a, cur_b, act, exp);
    end
  endtask

  // One full operation: start, bounded wait for done, check timing and results.
  // glitch >= 0 drives a spurious start with other operands at that RUN cycle.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input int glitch);
    int lat;
    int bcnt;
    int got;
    lat   = -1;
    bcnt  = 0;
    got   = 0;
    cur_a = int'(a);
    cur_b = int'(b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        got = 1;
        lat = k;
        break;
      end
      if (busy) bcnt++;
      if (k == glitch) begin
        start    = 1'b1;
        dividend = 8'd10;
        divisor  = 8'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done_seen", got, 1);
    chk("latency", lat, edz ? 0 : 8);
    chk("busy_width", bcnt, edz ? 0 : 8);
    chk("busy_at_done", int'(busy), 0);
    chk("quotient", int'(quotient), int'(eq));
    chk("remainder", int'(remainder), int'(er));
    chk("div_zero", int'(div_zero), int'(edz));
    @(posedge clk); #1;
    chk("done_single_cycle", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("quotient_hold", int'(quotient), int'(eq));
    chk("remainder_hold", int'(remainder), int'(er));
    chk("div_zero_hold", int'(div_zero), int'(edz));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_quotient"}, int'(quotient), 0);
    chk({tag, "_remainder"}, int'(remainder), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_div_zero"}, int'(div_zero), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ra;
    int rb;
    int rq;
    int rr;
    int cnt;

    vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   dz: 1'b0};
    vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0};
    vecs[2] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0};
    vecs[3] = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,   dz: 1'b0};
    vecs[4] = '{a: 8'd100, b: 8'd0,   q: 8'hFF,  r: 8'd100, dz: 1'b1};
    vecs[5] = '{a: 8'd9,   b: 8'd2,   q: 8'd4,   r: 8'd1,   dz: 1'b0};
    vecs[6] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   dz: 1'b0};
    vecs[7] = '{a: 8'd254, b: 8'd16,  q: 8'd15,  r: 8'd14,  dz: 1'b0};
    vecs[8] = '{a: 8'd128, b: 8'd128, q: 8'd1,   r: 8'd0,   dz: 1'b0};
    vecs[9] = '{a: 8'd7,   b: 8'd255, q: 8'd0,   r: 8'd7,   dz: 1'b0};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    #2;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, -1);
    end

    // Spurious start during RUN must be ignored, then the block stays idle.
    run_div(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 3);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (busy || done) cnt++;
    end
    chk("idle_after_ignored_start", cnt, 0);

    // Reset in the middle of a division aborts it with no done pulse.
    cur_a    = 200;
    cur_b    = 7;
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("busy_before_abort", int'(busy), 1);
    rst = 1'b1;
    #1;
    check_all_zero("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (busy || done) cnt++;
    end
    chk("no_done_after_abort", cnt, 0);
    run_div(8'd9, 8'd2, 8'd4, 8'd1, 1'b0, -1);

    // Reset release followed immediately by a start.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_div(8'd77, 8'd10, 8'd7, 8'd7, 1'b0, -1);

    // Randomized regression against plain integer division.
    for (int i = 0; i < 1000; i++) begin
      ra = int'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = 0;
      else rb = int'($urandom_range(0, 255));
      if (rb == 0) begin
        rq = 255;
        rr = ra;
      end else begin
        rq = ra / rb;
        rr = ra % rb;
      end
      run_div(8'(ra), 8'(rb), 8'(rq), 8'(rr), (rb == 0), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
